// File: rtl/mac_tx_arbiter.sv
// Round-robin owner of the single MAC TX send port, shared by the ARP and IP frame builders.
// Forwards the owner's byte stream with one cycle of registered latency and enforces a guard gap after every frame.
module mac_tx_arbiter #(
  parameter int P_GAP_CYCLES    = 32,
  parameter int P_START_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_arp_req,
  input  logic [7:0]  i_arp_data,
  input  logic [15:0] i_arp_len,
  input  logic        i_arp_valid,
  input  logic        i_arp_last,
  output logic        o_arp_grant,
  input  logic        i_ip_req,
  input  logic [7:0]  i_ip_data,
  input  logic [15:0] i_ip_len,
  input  logic        i_ip_valid,
  input  logic        i_ip_last,
  output logic        o_ip_grant,
  output logic [15:0] o_send_type,
  output logic [7:0]  o_send_data,
  output logic [15:0] o_send_len,
  output logic        o_send_last,
  output logic        o_send_valid,
  output logic        o_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_GAP} state_t;

  localparam logic [15:0] ETYPE_ARP = 16'h0806;
  localparam logic [15:0] ETYPE_IP  = 16'h0800;
  localparam logic [15:0] GAP_END   = 16'(P_GAP_CYCLES - 1);
  localparam logic [15:0] START_END = 16'(P_START_TIMEOUT - 1);

  state_t      state;
  logic        owner_ip;
  logic        rr_ip_first;
  logic [15:0] start_cnt;
  logic [15:0] gap_cnt;

  logic        own_valid;
  logic        own_last;
  logic [7:0]  own_data;
  logic [15:0] own_len;
  logic        in_frame;
  logic        fwd;
  logic        pick_ip;

  // Only the current owner's stream is visible downstream; the other side is ignored entirely.
  always_comb begin
    own_valid = i_arp_valid;
    own_last  = i_arp_last;
    own_data  = i_arp_data;
    own_len   = i_arp_len;
    if (owner_ip) begin
      own_valid = i_ip_valid;
      own_last  = i_ip_last;
      own_data  = i_ip_data;
      own_len   = i_ip_len;
    end
  end

  assign in_frame = (state == S_WAIT) || (state == S_SEND);
  assign fwd      = in_frame && own_valid;
  assign pick_ip  = i_ip_req && (!i_arp_req || rr_ip_first);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      owner_ip     <= 1'b0;
      rr_ip_first  <= 1'b0;
      start_cnt    <= 16'd0;
      gap_cnt      <= 16'd0;
      o_arp_grant  <= 1'b0;
      o_ip_grant   <= 1'b0;
      o_send_type  <= 16'd0;
      o_send_data  <= 8'd0;
      o_send_len   <= 16'd0;
      o_send_last  <= 1'b0;
      o_send_valid <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      o_timeout    <= 1'b0;
      o_send_valid <= fwd;
      o_send_data  <= fwd ? own_data : 8'h00;
      o_send_last  <= fwd && own_last;

      // Frame header is captured from the first accepted beat and held until the next frame starts.
      if (state == S_WAIT && own_valid) begin
        o_send_type <= owner_ip ? ETYPE_IP : ETYPE_ARP;
        o_send_len  <= own_len;
      end

      case (state)
        S_IDLE: begin
          if (i_arp_req || i_ip_req) begin
            owner_ip    <= pick_ip;
            rr_ip_first <= !pick_ip;
            o_arp_grant <= !pick_ip;
            o_ip_grant  <= pick_ip;
            start_cnt   <= 16'd0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (own_valid) begin
            if (own_last) begin
              o_arp_grant <= 1'b0;
              o_ip_grant  <= 1'b0;
              gap_cnt     <= 16'd0;
              state       <= S_GAP;
            end else begin
              state <= S_SEND;
            end
          end else if (start_cnt >= START_END) begin
            o_arp_grant <= 1'b0;
            o_ip_grant  <= 1'b0;
            o_timeout   <= 1'b1;
            gap_cnt     <= 16'd0;
            state       <= S_GAP;
          end else if (start_cnt != 16'hFFFF) begin
            start_cnt <= start_cnt + 16'd1;
          end
        end
        S_SEND: begin
          if (own_valid && own_last) begin
            o_arp_grant <= 1'b0;
            o_ip_grant  <= 1'b0;
            gap_cnt     <= 16'd0;
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt >= GAP_END) begin
            state <= S_IDLE;
          end else if (gap_cnt != 16'hFFFF) begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: directed vector table, hand-written corner sequences, and random traffic,
// all shadowed cycle by cycle by a frame-level reference model of the arbitration rules.
module tb_mac_tx_arbiter;
  localparam int P_GAP = 32;
  localparam int P_TO  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        arp_req, arp_valid, arp_last, ip_req, ip_valid, ip_last;
  logic [7:0]  arp_data, ip_data;
  logic [15:0] arp_len, ip_len;
  logic        arp_grant, ip_grant, send_last, send_valid, timeout;
  logic [15:0] send_type, send_len;
  logic [7:0]  send_data;

  mac_tx_arbiter #(.P_GAP_CYCLES(P_GAP), .P_START_TIMEOUT(P_TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_arp_req(arp_req), .i_arp_data(arp_data), .i_arp_len(arp_len),
    .i_arp_valid(arp_valid), .i_arp_last(arp_last), .o_arp_grant(arp_grant),
    .i_ip_req(ip_req), .i_ip_data(ip_data), .i_ip_len(ip_len),
    .i_ip_valid(ip_valid), .i_ip_last(ip_last), .o_ip_grant(ip_grant),
    .o_send_type(send_type), .o_send_data(send_data), .o_send_len(send_len),
    .o_send_last(send_last), .o_send_valid(send_valid), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          arp_req;
    bit          ip_req;
    int          nbytes;
    int          delay;
    bit          exp_ip;
    logic [15:0] exp_type;
    logic [15:0] exp_len;
    int          exp_beats;
    int          exp_timeouts;
  } vec_t;

  vec_t vecs[5];
  int   pvals[4] = '{0, 4, 40, 85};
  int   checks = 0;
  int   failures = 0;
  int   seen_beats, seen_last_at, seen_timeouts, seen_foreign;

  // Reference model: who owns the port, whether its frame has started, cycles waited, gap cycles left.
  int          m_owner = -1;
  bit          m_started = 1'b0;
  int          m_wait = 0;
  int          m_gap = 0;
  bit          m_ip_next = 1'b0;
  logic        e_arp_grant = 1'b0, e_ip_grant = 1'b0, e_valid = 1'b0, e_last = 1'b0, e_timeout = 1'b0;
  logic [7:0]  e_data = 8'd0;
  logic [15:0] e_type = 16'd0, e_len = 16'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic modelStep();
    bit          v, l;
    logic [7:0]  d;
    logic [15:0] ln;
    e_timeout = 1'b0;
    e_valid   = 1'b0;
    e_last    = 1'b0;
    e_data    = 8'd0;
    if (rst) begin
      m_owner = -1; m_gap = 0; m_ip_next = 1'b0; m_started = 1'b0; m_wait = 0;
      e_type = 16'd0; e_len = 16'd0; e_arp_grant = 1'b0; e_ip_grant = 1'b0;
      return;
    end
    if (m_owner >= 0) begin
      v  = (m_owner == 1) ? ip_valid : arp_valid;
      l  = (m_owner == 1) ? ip_last  : arp_last;
      d  = (m_owner == 1) ? ip_data  : arp_data;
      ln = (m_owner == 1) ? ip_len   : arp_len;
      if (v) begin
        e_valid = 1'b1;
        e_data  = d;
        e_last  = l;
        if (!m_started) begin
          m_started = 1'b1;
          e_type    = (m_owner == 1) ? 16'h0800 : 16'h0806;
          e_len     = ln;
        end
        if (l) begin
          m_owner = -1;
          m_gap   = P_GAP;
        end
      end else if (!m_started) begin
        m_wait++;
        if (m_wait == P_TO) begin
          m_owner   = -1;
          m_gap     = P_GAP;
          e_timeout = 1'b1;
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (arp_req || ip_req) begin
      m_owner   = (arp_req && ip_req) ? int'(m_ip_next) : (ip_req ? 1 : 0);
      m_ip_next = (m_owner == 0);
      m_started = 1'b0;
      m_wait    = 0;
    end
    e_arp_grant = (m_owner == 0);
    e_ip_grant  = (m_owner == 1);
  endtask

  task automatic checkOutput();
    check("cycle_model",
          64'({arp_grant, ip_grant, send_valid, send_data, send_last, send_type, send_len, timeout}),
          64'({e_arp_grant, e_ip_grant, e_valid, e_data, e_last, e_type, e_len, e_timeout}));
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    if (send_valid) seen_beats++;
    if (send_valid && send_last) seen_last_at = seen_beats;
    if (timeout) seen_timeouts++;
    if (send_valid && send_data[7]) seen_foreign++;
  endtask

  task automatic clearSeen();
    seen_beats = 0; seen_last_at = 0; seen_timeouts = 0; seen_foreign = 0;
  endtask

  task automatic applyStimulus(input bit side_ip, input bit v, input logic [7:0] d, input bit l,
                               input logic [15:0] len);
    if (side_ip) begin
      ip_valid = v; ip_data = d; ip_last = l; ip_len = len;
    end else begin
      arp_valid = v; arp_data = d; arp_last = l; arp_len = len;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    arp_req = 1'b0; ip_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic waitGrant(input int bound, output int n, output bit got_ip);
    n = 0;
    while (!(arp_grant || ip_grant) && n < bound) begin
      tick();
      n++;
    end
    got_ip = ip_grant;
    check("grant_arrived", 64'(arp_grant | ip_grant), 64'(1));
  endtask

  task automatic driveFrame(input bit side_ip, input int nbytes, input int delay, input logic [15:0] len);
    repeat (delay) tick();
    for (int i = 0; i < nbytes; i++) begin
      applyStimulus(side_ip, 1'b1, 8'(i + 1), (i == nbytes - 1), len);
      tick();
    end
    applyStimulus(side_ip, 1'b0, 8'd0, 1'b0, len);
  endtask

  initial begin
    int n;
    bit who;
    bit vin;
    int bad;
    int beats_in;

    vecs[0] = '{1'b1, 1'b0, 28, 0,  1'b0, 16'h0806, 16'd28, 28, 0};
    vecs[1] = '{1'b0, 1'b1, 46, 3,  1'b1, 16'h0800, 16'd46, 46, 0};
    vecs[2] = '{1'b1, 1'b1, 60, 1,  1'b0, 16'h0806, 16'd60, 60, 0};
    vecs[3] = '{1'b0, 1'b1, 1,  63, 1'b1, 16'h0800, 16'd1,  1,  0};
    vecs[4] = '{1'b0, 1'b1, 5,  64, 1'b1, 16'h0000, 16'd0,  0,  1};

    doReset();
    check("reset_state",
          64'({arp_grant, ip_grant, send_valid, send_data, send_last, send_type, send_len, timeout}), 64'(0));

    for (int k = 0; k < 5; k++) begin
      doReset();
      clearSeen();
      arp_req = vecs[k].arp_req;
      ip_req  = vecs[k].ip_req;
      waitGrant(10, n, who);
      check($sformatf("v%0d_grant_latency", k), 64'(n), 64'(1));
      check($sformatf("v%0d_winner_ip", k), 64'(who), 64'(vecs[k].exp_ip));
      arp_req = 1'b0;
      ip_req  = 1'b0;
      driveFrame(who, vecs[k].nbytes, vecs[k].delay, 16'(vecs[k].nbytes));
      repeat (4) tick();
      check($sformatf("v%0d_send_type", k), 64'(send_type), 64'(vecs[k].exp_type));
      check($sformatf("v%0d_send_len", k), 64'(send_len), 64'(vecs[k].exp_len));
      check($sformatf("v%0d_beats", k), 64'(seen_beats), 64'(vecs[k].exp_beats));
      check($sformatf("v%0d_last_at", k), 64'(seen_last_at), 64'(vecs[k].exp_beats));
      check($sformatf("v%0d_timeouts", k), 64'(seen_timeouts), 64'(vecs[k].exp_timeouts));
    end

    // Both builders requesting continuously must alternate, with the full guard gap between frames.
    doReset();
    arp_req = 1'b1;
    ip_req  = 1'b1;
    for (int f = 0; f < 3; f++) begin
      waitGrant(100, n, who);
      check($sformatf("rr_winner_ip_%0d", f), 64'(who), 64'(f % 2));
      if (f > 0) check($sformatf("rr_gap_%0d", f), 64'(n), 64'(P_GAP + 1));
      driveFrame(who, 8, 0, 16'd8);
      check($sformatf("rr_type_%0d", f), 64'(send_type), (f % 2 == 1) ? 64'(16'h0800) : 64'(16'h0806));
    end
    arp_req = 1'b0;
    ip_req  = 1'b0;

    // IP grant that never starts is revoked; ARP then waits out the gap.
    doReset();
    clearSeen();
    ip_req = 1'b1;
    waitGrant(10, n, who);
    check("to_owner_ip", 64'(who), 64'(1));
    ip_req  = 1'b0;
    arp_req = 1'b1;
    repeat (P_TO) tick();
    check("to_pulses", 64'(seen_timeouts), 64'(1));
    check("to_grant_dropped", 64'(ip_grant), 64'(0));
    check("to_no_valid", 64'(seen_beats), 64'(0));
    waitGrant(100, n, who);
    check("to_next_arp", 64'({arp_grant, ip_grant}), 64'(2'b10));
    check("to_gap", 64'(n), 64'(P_GAP + 1));
    arp_req = 1'b0;

    // Reset in the middle of a 100-byte frame, then round-robin must restart ARP-first.
    doReset();
    arp_req = 1'b1;
    waitGrant(10, n, who);
    arp_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(i + 1), 1'b0, 16'd100);
      tick();
    end
    check("pre_rst_valid", 64'(send_valid), 64'(1));
    applyStimulus(1'b0, 1'b1, 8'd11, 1'b0, 16'd100);
    rst = 1'b1;
    tick();
    check("rst_mid_frame",
          64'({arp_grant, ip_grant, send_valid, send_data, send_last, send_type, send_len, timeout}), 64'(0));
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    arp_req = 1'b1;
    ip_req  = 1'b1;
    waitGrant(10, n, who);
    check("rst_rr_arp_first", 64'({arp_grant, ip_grant}), 64'(2'b10));
    arp_req = 1'b0;
    ip_req  = 1'b0;

    // IP owner pauses for 3 cycles while the non-owner ARP side drives bytes with bit 7 set.
    doReset();
    clearSeen();
    ip_req = 1'b1;
    waitGrant(10, n, who);
    ip_req   = 1'b0;
    bad      = 0;
    beats_in = 0;
    for (int t = 0; t < 23; t++) begin
      vin = !(t >= 10 && t < 13);
      applyStimulus(1'b0, 1'b1, 8'h80 | 8'($urandom_range(0, 127)), 1'b0, 16'd9);
      applyStimulus(1'b1, vin, 8'(beats_in + 1), vin && (beats_in == 19), 16'd20);
      if (vin) beats_in++;
      tick();
      if (send_valid !== vin) bad++;
    end
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 16'd0);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0, 16'd0);
    repeat (2) tick();
    check("pause_pattern_errors", 64'(bad), 64'(0));
    check("pause_no_arp_bytes", 64'(seen_foreign), 64'(0));
    check("pause_ip_beats", 64'(seen_beats), 64'(20));

    // Random traffic, including non-owner noise, idle owners and occasional resets.
    doReset();
    for (int seg = 0; seg < 8; seg++) begin
      repeat (500) begin
        rst       = ($urandom_range(0, 699) == 0);
        arp_req   = ($urandom_range(0, 2) != 0);
        ip_req    = ($urandom_range(0, 2) != 0);
        arp_valid = ($urandom_range(0, 99) < pvals[seg % 4]);
        ip_valid  = ($urandom_range(0, 99) < pvals[seg % 4]);
        arp_last  = ($urandom_range(0, 7) == 0);
        ip_last   = ($urandom_range(0, 7) == 0);
        arp_data  = 8'($urandom);
        ip_data   = 8'($urandom);
        arp_len   = 16'($urandom);
        ip_len    = 16'($urandom);
        tick();
      end
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
